// File: rtl/gift64_iter_core.sv
// Iterative GIFT-64 encryption core: UNROLL rounds per clock, on-the-fly key schedule and
// round constants, start/ready input handshake and valid/ready output handshake.
module gift64_iter_core #(
   parameter int unsigned NR     = 28,
   parameter int unsigned UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         ready,
   input  logic [63:0]  din,
   input  logic [127:0] key,
   output logic [63:0]  dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic [4:0]   round
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [4:0]  LAST = 5'(NR - UNROLL);
   localparam logic [4:0]  STEP = 5'(UNROLL);
   // GIFT S-box, entry n in bits [4n+3:4n]
   localparam logic [63:0] SBOX = 64'hE805_7BD2_93F6_C4A1;

   logic [1:0]   fsm_q;
   logic [63:0]  state_q;
   logic [63:0]  dout_q;
   logic [127:0] key_q;
   logic [5:0]   lfsr_q;
   logic [4:0]   round_q;

   logic [63:0]  st_c [0:UNROLL];
   logic [127:0] ks_c [0:UNROLL];
   logic [5:0]   lf_c [0:UNROLL];

   function automatic logic [15:0] nib_rotl(input logic [15:0] w, input logic [1:0] amt);
      logic [15:0] r;
      logic [3:0]  x;
      r = w;
      for (int n = 0; n < 4; n++) begin
         x = w[4*n +: 4];
         case (amt)
            2'd1:    r[4*n +: 4] = {x[2:0], x[3]};
            2'd2:    r[4*n +: 4] = {x[1:0], x[3:2]};
            2'd3:    r[4*n +: 4] = {x[0], x[3:1]};
            default: r[4*n +: 4] = x;
         endcase
      end
      return r;
   endfunction

   // P1/P2/P3 rotate every nibble left by 1/2/3 bits; R1/R2/R3 rotate the word right by 4/8/12.
   function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [31:0] rk,
                                            input logic [5:0] lf, input logic [1:0] v);
      logic [63:0] x;
      logic [15:0] a, b, c;
      x = s ^ {rk, 16'h0000, 8'h80, 2'b00, lf};
      for (int n = 0; n < 16; n++) begin
         x[4*n +: 4] = SBOX[4*x[4*n +: 4] +: 4];
      end
      case (v)
         2'd0: begin
            a = nib_rotl(x[47:32], 2'd1);
            b = nib_rotl(x[31:16], 2'd2);
            c = nib_rotl(x[15:0], 2'd3);
         end
         2'd1: begin
            a = {x[35:32], x[47:36]};
            b = {x[23:16], x[31:24]};
            c = {x[11:0], x[15:12]};
         end
         2'd2: begin
            a = nib_rotl(x[47:32], 2'd3);
            b = nib_rotl(x[31:16], 2'd2);
            c = nib_rotl(x[15:0], 2'd1);
         end
         default: begin
            a = {x[43:32], x[47:44]};
            b = {x[23:16], x[31:24]};
            c = {x[3:0], x[15:4]};
         end
      endcase
      return {x[63:48], a, b, c};
   endfunction

   // {W7..W0} <- {W1 ror 2, W0 ror 12, W7..W2}
   function automatic logic [127:0] key_next(input logic [127:0] k);
      return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
   endfunction

   always_comb begin
      st_c[0] = state_q;
      ks_c[0] = key_q;
      lf_c[0] = lfsr_q;
      for (int i = 0; i < int'(UNROLL); i++) begin
         lf_c[i+1] = {lf_c[i][4:0], lf_c[i][5] ^ lf_c[i][4] ^ 1'b1};
         st_c[i+1] = round_fn(st_c[i], ks_c[i][31:0], lf_c[i+1], 2'(round_q[1:0] + 2'(i)));
         ks_c[i+1] = key_next(ks_c[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         key_q   <= '0;
         lfsr_q  <= '0;
         round_q <= '0;
         dout_q  <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (start) begin
                  fsm_q   <= RUN;
                  state_q <= din;
                  key_q   <= key;
                  lfsr_q  <= '0;
                  round_q <= '0;
               end
            end
            RUN: begin
               state_q <= st_c[UNROLL];
               key_q   <= ks_c[UNROLL];
               lfsr_q  <= lf_c[UNROLL];
               round_q <= round_q + STEP;
               if (round_q == LAST) begin
                  fsm_q  <= DONE;
                  dout_q <= st_c[UNROLL];
               end
            end
            DONE: begin
               if (dout_ready) fsm_q <= IDLE;
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign ready      = (fsm_q == IDLE);
   assign dout_valid = (fsm_q == DONE);
   assign dout       = dout_q;
   assign round      = round_q;

endmodule
